// File: rtl/sram_bridge_pkg.sv
// Shared types and sizing helpers for the host-to-SRAM bridge.
package sram_bridge_pkg;

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_e;

  function automatic int beats_of(input int data_w, input int dq_w);
    return data_w / dq_w;
  endfunction

  // Counter width that stays legal (>= 1 bit) when the count range is 1.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int DATA_W_DEF      = 32;
  localparam int DQ_W_DEF        = 16;
  localparam int WAIT_CYCLES_DEF = 2;
  localparam int BEATS           = beats_of(DATA_W_DEF, DQ_W_DEF);
  localparam int BEAT_CNT_W      = cnt_w(BEATS);
  localparam int WAIT_CNT_W      = cnt_w(WAIT_CYCLES_DEF);

endpackage

// File: rtl/sram_beat_counter.sv
// Wait-cycle / beat sequencer; clears itself whenever the bridge leaves ACCESS.
module sram_beat_counter #(
  parameter int BEATS_N = 2,
  parameter int WAIT_N  = 2,
  parameter int BC_W    = 1,
  parameter int WC_W    = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en_i,
  output logic [BC_W-1:0] beat_o,
  output logic            beat_last_o,
  output logic            last_beat_o
);

  logic [WC_W-1:0] wait_q, wait_d;
  logic [BC_W-1:0] beat_q, beat_d;

  assign beat_o      = beat_q;
  assign beat_last_o = (wait_q == WC_W'(WAIT_N - 1));
  assign last_beat_o = beat_last_o && (beat_q == BC_W'(BEATS_N - 1));

  always_comb begin
    wait_d = wait_q;
    beat_d = beat_q;
    if (!en_i) begin
      wait_d = '0;
      beat_d = '0;
    end else if (beat_last_o) begin
      wait_d = '0;
      beat_d = beat_q + BC_W'(1);
    end else begin
      wait_d = wait_q + WC_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wait_q <= '0;
      beat_q <= '0;
    end else begin
      wait_q <= wait_d;
      beat_q <= beat_d;
    end
  end

endmodule

// File: rtl/sram_bridge.sv
// Host word port to narrow asynchronous SRAM: one request becomes BEATS
// little-endian beats of WAIT_CYCLES cycles each, host stalled via ready.
module sram_bridge
  import sram_bridge_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int DQ_W        = 16,
  parameter int SRAM_ADDR_W = 18,
  parameter int WAIT_CYCLES = 2,
  parameter int BASE_ADDR   = 1024
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en,
  input  logic                   rd_en,
  input  logic [31:0]            address,
  input  logic [DATA_W-1:0]      write_data,
  output logic [DATA_W-1:0]      read_data,
  output logic                   ready,
  output logic [SRAM_ADDR_W-1:0] SRAM_ADDR,
  inout  wire  [DQ_W-1:0]        SRAM_DQ,
  output logic                   SRAM_WE_N
);

  localparam int NBEATS = beats_of(DATA_W, DQ_W);
  localparam int BC_W   = cnt_w(NBEATS);
  localparam int WC_W   = cnt_w(WAIT_CYCLES);
  localparam int SHIFT  = $clog2(DQ_W / 8);

  state_e                 state_q, state_d;
  logic [SRAM_ADDR_W-1:0] addr_q, base_d;
  logic [DATA_W-1:0]      wdata_q, rbuf_q, rbuf_d, read_data_q;
  logic                   op_wr_q, dq_oe, req;
  logic [BC_W-1:0]        beat;
  logic                   beat_last, last_beat;

  sram_beat_counter #(
    .BEATS_N(NBEATS), .WAIT_N(WAIT_CYCLES), .BC_W(BC_W), .WC_W(WC_W)
  ) u_cnt (
    .clk(clk), .rst(rst), .en_i(state_q == ACCESS),
    .beat_o(beat), .beat_last_o(beat_last), .last_beat_o(last_beat)
  );

  assign req       = wr_en | rd_en;
  // Offset arithmetic wraps modulo 2^SRAM_ADDR_W, including addresses below BASE_ADDR.
  assign base_d    = SRAM_ADDR_W'((address - 32'(BASE_ADDR)) >> SHIFT);
  assign SRAM_DQ   = dq_oe ? wdata_q[int'(beat)*DQ_W +: DQ_W] : {DQ_W{1'bz}};
  assign read_data = read_data_q;

  always_comb begin
    rbuf_d = rbuf_q;
    rbuf_d[int'(beat)*DQ_W +: DQ_W] = SRAM_DQ;
  end

  always_comb begin
    state_d   = state_q;
    ready     = 1'b0;
    SRAM_WE_N = 1'b1;
    SRAM_ADDR = '0;
    dq_oe     = 1'b0;
    unique case (state_q)
      IDLE: begin
        ready = ~req;
        if (req) state_d = ACCESS;
      end
      ACCESS: begin
        SRAM_ADDR = addr_q + SRAM_ADDR_W'(beat);
        SRAM_WE_N = ~op_wr_q;
        dq_oe     = op_wr_q;
        if (last_beat) state_d = DONE;
      end
      DONE: begin
        // Unconditional return so a request still held here is not re-accepted.
        ready   = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      op_wr_q     <= 1'b0;
      rbuf_q      <= '0;
      read_data_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && req) begin
        addr_q  <= base_d;
        wdata_q <= write_data;
        op_wr_q <= wr_en;
      end
      if (state_q == ACCESS && !op_wr_q && beat_last) begin
        rbuf_q <= rbuf_d;
        if (last_beat) read_data_q <= rbuf_d;
      end
    end
  end

endmodule

// File: doc/sram_bridge.md
SRAM_BRIDGE -- requirements
Module: sram_bridge

Interface
REQ-001 Parameter DATA_W, default 32: host word width; SHALL be a multiple of DQ_W.
REQ-002 Parameter DQ_W, default 16: SRAM data bus width.
REQ-003 Parameter SRAM_ADDR_W, default 18: SRAM halfword address width.
REQ-004 Parameter WAIT_CYCLES, default 2, minimum 1: clock cycles per SRAM beat.
REQ-005 Parameter BASE_ADDR, default 1024: host byte address mapped to SRAM address 0.
REQ-006 clk  in  1  single clock; all state updates on its rising edge.
REQ-007 rst  in  1  synchronous, active-high reset.
REQ-008 wr_en  in  1  host write request.
REQ-009 rd_en  in  1  host read request.
REQ-010 address  in  32  host byte address.
REQ-011 write_data  in  DATA_W  host write word.
REQ-012 read_data  out  DATA_W  last completed read word.
REQ-013 ready  out  1  high = no access in progress; low = host pipeline SHALL stall.
REQ-014 SRAM_ADDR  out  SRAM_ADDR_W  SRAM halfword address.
REQ-015 SRAM_DQ  inout  DQ_W  SRAM data; driven only during write beats, else high-Z.
REQ-016 SRAM_WE_N  out  1  active-low SRAM write enable.

Function
REQ-017 BEATS = DATA_W/DQ_W; the FSM SHALL have states IDLE, ACCESS and DONE.
REQ-018 In IDLE with wr_en or rd_en high, the block SHALL latch address, write_data and operation, drive ready low combinationally in that cycle, and go to ACCESS.
REQ-019 When wr_en and rd_en are both high, the write SHALL be performed and the read ignored.
REQ-020 ACCESS SHALL last exactly BEATS*WAIT_CYCLES cycles, each beat WAIT_CYCLES cycles long, with ready low throughout.
REQ-021 Beat k SHALL address ((address - BASE_ADDR) >> log2(DQ_W/8)) + k, truncated to SRAM_ADDR_W bits (wraps modulo 2^SRAM_ADDR_W).
REQ-022 Little-endian packing: beat k carries bits [(k+1)*DQ_W-1 : k*DQ_W].
REQ-023 Write beat: SRAM_DQ driven with the beat slice and SRAM_WE_N low for every cycle of the beat.
REQ-024 Read beat: SRAM_WE_N high, SRAM_DQ high-Z; the slice SHALL be captured on the last cycle of the beat.
REQ-025 DONE SHALL last one cycle, with ready high, and with read_data holding the full word for reads or unchanged for writes; the next state SHALL be IDLE unconditionally, so a request still held in DONE is not re-accepted.
REQ-026 Total ready-low cycles per access = 1 + BEATS*WAIT_CYCLES.
REQ-027 In IDLE with no request: ready high, SRAM_WE_N high, SRAM_DQ high-Z, SRAM_ADDR 0.

Reset
REQ-028 rst high SHALL, on the next edge, force IDLE, read_data 0, beat and wait counters 0, SRAM_WE_N high, SRAM_DQ high-Z, SRAM_ADDR 0, and ready high.
REQ-029 Reset mid-ACCESS SHALL abort the access; beats already written remain in SRAM, and no further beat is issued.

Structure
REQ-030 Package sram_bridge_pkg SHALL hold the state enum, BEATS, and the counter-width constants (clog2 of BEATS and WAIT_CYCLES).
REQ-031 One sub-module, sram_beat_counter, SHALL generate the wait-cycle count, beat index, last-cycle-of-beat and last-beat strobes.

Verification
REQ-032 Defaults: write 0xDEADBEEF to 1024 -> SRAM[0]=0xBEEF, SRAM[1]=0xDEAD, SRAM_WE_N low 4 cycles, ready low 5 cycles.
REQ-033 Then read 1024 -> read_data = 0xDEADBEEF in the DONE cycle, with ready high.
REQ-034 DATA_W=64, WAIT_CYCLES=1: write 0x0123456789ABCDEF to 1032 -> SRAM[4..7] = 0xCDEF, 0x89AB, 0x4567, 0x0123, ready low 5 cycles.
REQ-035 Defaults: rst high in the 2nd ACCESS cycle of a write to 1024 -> next cycle IDLE, ready=1, SRAM_WE_N=1, SRAM_DQ high-Z, read_data=0, SRAM[1] unchanged.
REQ-036 wr_en and rd_en both high, address 1028, data 0x11112222 -> SRAM[2]=0x2222, SRAM[3]=0x1111, read_data unchanged.
REQ-037 rd_en held through DONE then dropped -> exactly one access; rd_en held for two instructions -> second access starts the cycle after DONE.
